// File: rtl/fb_port_arbiter_pkg.sv
// Shared Tron types: frame-buffer geometry and the port-arbiter state encoding.
package tron_types;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 3;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    typedef enum logic [0:0] {
        DISP_PRI  = 1'b0,
        GAME_LOCK = 1'b1
    } ArbState;

endpackage

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM between VGA scanout (priority) and game logic,
// with a starvation guarantee for the game and a short lock for read-modify-write pairs.
module fb_port_arbiter
    import tron_types::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 3,
    parameter int LOCK_MAX     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic              gl_lock,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_gnt,
    output logic              gl_rvalid,
    output logic [DATA_W-1:0] gl_rdata,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_enabled,
    output logic [DATA_W-1:0] ram_write_data
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);
    localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_MAX - 1);

    ArbState           state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic              disp_rvalid_reg, gl_rvalid_reg;

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        disp_gnt      = 1'b0;
        gl_gnt        = 1'b0;
        unique case (state_reg)
            DISP_PRI: begin
                if (wait_cnt_reg == WAIT_LIMIT) begin
                    gl_gnt = gl_req;
                end else begin
                    disp_gnt = disp_req;
                    gl_gnt   = gl_req & ~disp_req;
                end
                if (gl_gnt && !gl_we && gl_lock) begin
                    state_next    = GAME_LOCK;
                    lock_cnt_next = '0;
                end
            end
            GAME_LOCK: begin
                gl_gnt        = gl_req;
                lock_cnt_next = lock_cnt_reg + 1'b1;
                // The entry read already held the port once, so the forced release
                // looks at the count including this cycle.
                if (!gl_req || (gl_gnt && !gl_lock) || (lock_cnt_next >= LOCK_LAST)) begin
                    state_next = DISP_PRI;
                end
            end
            default: state_next = DISP_PRI;
        endcase
        if (reset) begin
            disp_gnt = 1'b0;
            gl_gnt   = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!gl_req || gl_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= DISP_PRI;
            wait_cnt_reg    <= '0;
            lock_cnt_reg    <= '0;
            disp_rvalid_reg <= 1'b0;
            gl_rvalid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            lock_cnt_reg    <= lock_cnt_next;
            disp_rvalid_reg <= disp_gnt;
            gl_rvalid_reg   <= gl_gnt & ~gl_we;
        end
    end

    assign ram_address       = gl_gnt ? gl_addr : (disp_gnt ? disp_addr : '0);
    assign ram_write_enabled = gl_gnt & gl_we;
    assign ram_write_data    = (gl_gnt | disp_gnt) ? gl_wdata : '0;

    // A read launched just before reset must not surface while reset is held.
    assign disp_rvalid = disp_rvalid_reg & ~reset;
    assign gl_rvalid   = gl_rvalid_reg & ~reset;
    assign disp_rdata  = ram_read_data;
    assign gl_rdata    = ram_read_data;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: directed scenarios plus randomized traffic.
module tb_fb_port_arbiter;
    import tron_types::*;

    localparam int LIMIT = 3;
    localparam int LMAX  = 2;
    localparam int NPIX  = FB_WIDTH * FB_HEIGHT;
    localparam logic [18:0] HOT_ADDR = 19'(320 * 120 + 20);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0, gl_req = 1'b0, gl_we = 1'b0, gl_lock = 1'b0;
    logic [18:0] disp_addr = '0, gl_addr = '0, ram_address;
    logic [2:0]  gl_wdata = '0, disp_rdata, gl_rdata, ram_read_data, ram_write_data;
    logic        disp_gnt, disp_rvalid, gl_gnt, gl_rvalid, ram_write_enabled;

    always #5 clock = ~clock;

    fb_port_arbiter #(.ADDR_W(19), .DATA_W(3), .STARVE_LIMIT(LIMIT), .LOCK_MAX(LMAX)) dut (
        .clock(clock), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .gl_req(gl_req), .gl_we(gl_we), .gl_lock(gl_lock), .gl_addr(gl_addr),
        .gl_wdata(gl_wdata), .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
        .ram_read_data(ram_read_data), .ram_address(ram_address),
        .ram_write_enabled(ram_write_enabled), .ram_write_data(ram_write_data)
    );

    // Frame-buffer RAM environment: one synchronous port, read-before-write.
    logic [2:0] mem [NPIX];
    always @(posedge clock) begin
        if (ram_write_enabled) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end

    typedef struct {
        int         due;
        logic [2:0] data;
    } rsp_t;
    rsp_t disp_q[$];
    rsp_t gl_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: expected RAM contents and arbitration history.
    logic [2:0] ref_mem [NPIX];
    bit m_lock   = 0;
    int m_held   = 0;
    int m_starve = 0;
    bit exp_d, exp_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic step(input bit rst, input bit dreq, input logic [18:0] daddr,
                        input bit greq, input bit gwe, input bit glock,
                        input logic [18:0] gaddr, input logic [2:0] gwd);
        logic [18:0] eaddr;
        @(posedge clock);
        cyc++;
        #1;
        reset = rst; disp_req = dreq; disp_addr = daddr;
        gl_req = greq; gl_we = gwe; gl_lock = glock; gl_addr = gaddr; gl_wdata = gwd;
        if (rst) begin
            disp_q.delete();
            gl_q.delete();
        end
        if (rst) begin
            exp_d = 0; exp_g = 0;
        end else if (m_lock || m_starve >= LIMIT) begin
            exp_d = 0; exp_g = greq;
        end else begin
            exp_d = dreq; exp_g = greq && !dreq;
        end
        #1;
        eaddr = exp_g ? gaddr : (exp_d ? daddr : 19'd0);
        check("grants", 32'({disp_gnt, gl_gnt}), 32'({exp_d, exp_g}));
        check("ram_bus", 32'({ram_address, ram_write_enabled, ram_write_data}),
              32'({eaddr, exp_g && gwe, (exp_g || exp_d) ? gwd : 3'd0}));
        if (exp_d) disp_q.push_back('{cyc + 1, ref_mem[daddr]});
        if (exp_g && !gwe) gl_q.push_back('{cyc + 1, ref_mem[gaddr]});
        // Effect of the coming clock edge.
        if (rst) begin
            m_lock = 0; m_held = 0; m_starve = 0;
        end else begin
            if (exp_g && gwe) ref_mem[gaddr] = gwd;
            if (m_lock) begin
                m_held++;
                if (!greq || (exp_g && !glock) || m_held >= LMAX) m_lock = 0;
            end else if (exp_g && !gwe && glock) begin
                m_lock = 1; m_held = 1;
            end
            m_starve = (greq && !exp_g) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
    endtask

    // Holds a game request until the DUT grants it; n is the number of cycles taken.
    task automatic game_op(input bit dreq, input logic [18:0] daddr, input bit we,
                           input bit lock, input logic [18:0] a, input logic [2:0] d,
                           output int n);
        n = 0;
        do begin
            step(0, dreq, daddr, 1, we, lock, a, d);
            n++;
        end while (!gl_gnt && n < 20);
        if (n >= 20) check("game_grant_timeout", 32'(gl_gnt), 32'd1);
    endtask

    always @(negedge clock) begin
        rsp_t r;
        if (disp_rvalid) begin
            if (disp_q.size() == 0) check("disp_rvalid_spurious", 32'(disp_rvalid), 32'd0);
            else begin
                r = disp_q.pop_front();
                check("disp_rdata", 32'(disp_rdata), 32'(r.data));
                check("disp_latency", cyc, r.due);
            end
        end else if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
            void'(disp_q.pop_front());
            check("disp_rvalid_missing", 32'(disp_rvalid), 32'd1);
        end
        if (gl_rvalid) begin
            if (gl_q.size() == 0) check("gl_rvalid_spurious", 32'(gl_rvalid), 32'd0);
            else begin
                r = gl_q.pop_front();
                check("gl_rdata", 32'(gl_rdata), 32'(r.data));
                check("gl_latency", cyc, r.due);
            end
        end else if (gl_q.size() > 0 && gl_q[0].due <= cyc) begin
            void'(gl_q.pop_front());
            check("gl_rvalid_missing", 32'(gl_rvalid), 32'd1);
        end
    end

    initial begin
        int n;
        bit dp, gp, gw, gk, rst;
        logic [18:0] da, ga;
        logic [2:0]  gd, v;
        for (int i = 0; i < NPIX; i++) begin
            v = (i == int'(HOT_ADDR)) ? 3'b100 : 3'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end

        // Reset held two cycles with both requesters active, then display first.
        step(1, 1, 19'd5, 1, 0, 0, 19'd6, 3'd0);
        step(1, 1, 19'd5, 1, 0, 0, 19'd6, 3'd0);
        check("reset_rvalid", 32'({disp_rvalid, gl_rvalid}), 32'd0);
        step(0, 1, 19'd5, 1, 0, 0, 19'd6, 3'd0);
        check("post_reset_disp_gnt", 32'(disp_gnt), 32'd1);
        step(0, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);

        // Display priority with starvation release on the fourth cycle.
        game_op(1, 19'd100, 0, 0, 19'd200, 3'd0, n);
        check("starve_wait", n, 4);
        repeat (6) step(0, 1, 19'd101, 0, 0, 0, 19'd0, 3'd0);

        // Single read, one-cycle latency.
        step(0, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);
        game_op(0, 19'd0, 0, 0, HOT_ADDR, 3'd0, n);
        check("latency_grant", n, 1);
        step(0, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);
        check("latency_rvalid", 32'({gl_rvalid, gl_rdata, disp_rvalid}), 32'({1'b1, 3'b100, 1'b0}));

        // Locked read-modify-write under constant display pressure.
        game_op(1, 19'd300, 0, 1, HOT_ADDR, 3'd0, n);
        game_op(1, 19'd301, 1, 0, HOT_ADDR, 3'b000, n);
        check("rmw_write_back_to_back", n, 1);
        step(0, 1, 19'd302, 0, 0, 0, 19'd0, 3'd0);
        check("rmw_release_disp", 32'(disp_gnt), 32'd1);

        // Lock timeout: the third locked read must re-arbitrate.
        step(0, 1, 19'd303, 0, 0, 0, 19'd0, 3'd0);
        game_op(1, 19'd304, 0, 1, 19'd10, 3'd0, n);
        game_op(1, 19'd305, 0, 1, 19'd11, 3'd0, n);
        check("lock_second_read", n, 1);
        game_op(1, 19'd306, 0, 1, 19'd12, 3'd0, n);
        check("lock_timeout_wait", n, 4);
        step(0, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);

        // Reset right after a granted read drops its response.
        game_op(0, 19'd0, 0, 1, 19'd13, 3'd0, n);
        step(1, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);
        check("reset_drops_rvalid", 32'(gl_rvalid), 32'd0);
        step(0, 1, 19'd14, 1, 0, 1, 19'd15, 3'd0);
        check("reset_back_to_disp_pri", 32'({disp_gnt, gl_gnt}), 32'b10);

        // Randomized traffic; requests stay held until the model grants them.
        dp = 0; gp = 0; da = '0; ga = '0; gw = 0; gk = 0; gd = '0;
        repeat (2000) begin
            if (!dp) begin
                dp = ($urandom_range(0, 3) != 0);
                da = $urandom_range(0, 1) ? 19'($urandom_range(0, 7)) : 19'($urandom_range(0, NPIX - 1));
            end
            if (!gp) begin
                gp = 1'($urandom_range(0, 1));
                gw = 1'($urandom_range(0, 1));
                gk = 1'($urandom_range(0, 1));
                ga = $urandom_range(0, 1) ? 19'($urandom_range(0, 7)) : 19'($urandom_range(0, NPIX - 1));
                gd = 3'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
            step(rst, dp, da, gp, gw, gk, ga, gd);
            if (exp_d || rst) dp = 0;
            if (exp_g || rst) gp = 0;
        end

        repeat (3) step(0, 0, 19'd0, 0, 0, 0, 19'd0, 3'd0);
        check("queues_drained", 32'(disp_q.size() + gl_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port 320x240x3-bit frame-buffer RAM between two requesters: the VGA scanout reader (display) and the game logic (read/write).
- Display has priority. A starvation counter guarantees the game a slot.
- A lock mechanism keeps a game read-modify-write pair (trail erase on player loss) atomic.
- Sits between both requesters and the RAM's one synchronous port (1-cycle read latency).

Parameters:
ADDR_W, 19, frame-buffer address width (320*240 = 76800 pixels)
DATA_W, 3, pixel colour width
STARVE_LIMIT, 3, consecutive denied game cycles before a game grant is forced
LOCK_MAX, 2, maximum cycles the game may hold the port in GAME_LOCK

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
disp_req  in  1  display read request; held until granted
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display access issued to RAM this cycle
disp_rvalid  out  1  disp_rdata valid (registered, 1 cycle after disp_gnt)
disp_rdata  out  DATA_W  read pixel (ram_read_data passthrough)
gl_req  in  1  game request; held until granted
gl_we  in  1  1 = write, 0 = read
gl_lock  in  1  with a granted read, reserve the port for the following access
gl_addr  in  ADDR_W  game address
gl_wdata  in  DATA_W  game write data
gl_gnt  out  1  game access issued to RAM this cycle
gl_rvalid  out  1  gl_rdata valid (registered, 1 cycle after a granted game read)
gl_rdata  out  DATA_W  read pixel (ram_read_data passthrough)
ram_address  out  ADDR_W  RAM address
ram_write_enabled  out  1  RAM write strobe
ram_write_data  out  DATA_W  RAM write data

Behaviour:
- Reset values:
  - state = DISP_PRI; wait_cnt = 0; lock_cnt = 0.
  - disp_rvalid = gl_rvalid = 0.
  - Any read in flight is discarded: no rvalid in the cycle after reset.
- Grants are combinational from the current state and requests. At most one grant per cycle.
- RAM mux:
  - Granted requester drives ram_address.
  - ram_write_enabled = gl_gnt & gl_we.
  - ram_write_data = gl_wdata.
  - No grant: address 0, write-enable 0, data 0.
- Read return: rvalid is registered from (gnt & ~we) of the previous cycle. rdata = ram_read_data unconditionally; it is meaningful only while the matching rvalid = 1. Writes produce no rvalid.
- State DISP_PRI:
  - wait_cnt < STARVE_LIMIT: disp_gnt = disp_req; gl_gnt = gl_req & ~disp_req.
  - wait_cnt == STARVE_LIMIT: gl_gnt = gl_req; disp_gnt = 0. The display tolerates the skipped cycle via its own line buffer.
  - gl_gnt & ~gl_we & gl_lock -> GAME_LOCK, lock_cnt = 0.
- State GAME_LOCK:
  - gl_gnt = gl_req; disp_gnt = 0. lock_cnt increments each cycle.
  - Exit to DISP_PRI when any of: gl_req = 0; a game access is granted with gl_lock = 0; lock_cnt == LOCK_MAX-1 (forced release).
  - A granted locked read stays in GAME_LOCK; the lock is re-armed but lock_cnt is not reset.
- wait_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when gl_req & ~gl_gnt.
  - Clears on gl_gnt, or when gl_req = 0.
  - Saturates at STARVE_LIMIT.
- Simultaneous requests with wait_cnt < limit: display wins.
- Back-to-back grants to alternating requesters are legal. Each rvalid is tagged independently, so no data mixing.
- Same-address write then read in consecutive cycles: RAM semantics apply; the arbiter adds no forwarding.
- Reset asserted mid-lock: returns to DISP_PRI next cycle and drops any pending rvalid.

Decomposition:
- Shared package tron_types gains:
  - enum ArbState {DISP_PRI, GAME_LOCK} (logic [0:0]).
  - Constants FB_ADDR_W = 19, FB_DATA_W = 3, FB_WIDTH = 320, FB_HEIGHT = 240.
- No sub-module. The counters, the 2-state FSM and the rvalid tag registers stay flat in one module.

Test Plan:
- Reset: hold reset 2 cycles, both requests high -> all gnt/rvalid 0 during reset; disp_gnt = 1 on the first cycle after.
- Display priority: disp_req = 1 for 10 cycles, gl_req read held from cycle 0 -> gl_denied for cycles 0-2; gl_gnt = 1 and disp_gnt = 0 at cycle 3; gl_rvalid = 1 at cycle 4; disp_gnt resumes at cycle 4.
- Read latency: gl read at address 320*120+20 where RAM holds 3'b100 -> gl_rvalid = 1, gl_rdata = 3'b100 exactly one cycle later; disp_rvalid stays 0.
- Lock RMW: gl read with gl_lock = 1, then write 3'b000 with gl_lock = 0 next cycle, disp_req constantly high -> gl_gnt on 2 consecutive cycles; disp_gnt = 0 for both; state back in DISP_PRI on the third cycle.
- Lock timeout: gl_lock = 1 on three consecutive granted reads, LOCK_MAX = 2 -> third access goes through DISP_PRI arbitration; display granted on that cycle.
- Reset mid-read: game read granted, reset asserted next cycle -> gl_rvalid = 0; state = DISP_PRI after reset.
